// File: rtl/fb_rect_writer_pkg.sv
// Shared types and constants for the framebuffer rectangle writer.
package fb_pkg;

    localparam int unsigned FB_W = 280;
    localparam int unsigned FB_H = 192;
    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 24;

    typedef struct packed {
        logic [8:0]    x;
        logic [7:0]    y;
        logic [8:0]    w;
        logic [7:0]    h;
        logic [DW-1:0] color;
    } rect_cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} fb_wr_state_t;

    // Linear framebuffer address of pixel (x,y), row-major.
    function automatic logic [AW-1:0] fb_addr(input logic [8:0] x, input logic [7:0] y);
        return AW'(32'(y) * 32'(FB_W) + 32'(x));
    endfunction

endpackage

// File: rtl/fb_rect_writer_addr_calc.sv
// Row base address y*FB_W; shift-add for the 280-wide screen, plain multiply otherwise.
module fb_addr_calc
    import fb_pkg::*;
(
    input  logic [7:0]    y,
    output logic [AW-1:0] row_base
);

    generate
        if (FB_W == 280) begin : g_shift_add
            logic [AW-1:0] y_ext;
            assign y_ext    = AW'(y);
            // 280 = 256 + 16 + 8
            assign row_base = (y_ext << 8) + (y_ext << 4) + (y_ext << 3);
        end else begin : g_mul
            assign row_base = AW'(32'(y) * 32'(FB_W));
        end
    endgenerate

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill client of the framebuffer write port, one pixel per clock, row-major.
// Build option: define FB_RECT_CLIP_EN to clip rectangles to the screen; without it,
// any rectangle reaching past the screen edge is rejected with err.
// done/err are registered from the DONE state, so they appear the cycle after it and
// cmd_ready returns one cycle after done.
module fb_rect_writer
    import fb_pkg::*;
(
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [8:0]    cmd_x,
    input  logic [7:0]    cmd_y,
    input  logic [8:0]    cmd_w,
    input  logic [7:0]    cmd_h,
    input  logic [23:0]   cmd_color,
    output logic [15:0]   fb_wadr,
    output logic [23:0]   fb_d,
    output logic          fb_we,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [9:0] W10 = 10'(FB_W);
    localparam logic [9:0] H10 = 10'(FB_H);

    fb_wr_state_t  state_q, state_d;
    rect_cmd_t     cmd_q, cmd_d;
    logic [9:0]    x1_q, x1_d, y1_q, y1_d;
    logic [8:0]    col_q, col_d;
    logic [7:0]    line_q, line_d;
    logic [AW-1:0] row_base_q, row_base_d, wadr_q, wadr_d;
    logic [DW-1:0] fbd_q, fbd_d;
    logic          we_q, we_d, ready_q, ready_d, busy_q, busy_d;
    logic          done_q, done_d, err_q, err_d, reject_q, reject_d;

    logic [AW-1:0] row_base_calc;
    logic [9:0]    x_end, y_end;
    logic          accept, empty, skip;

    fb_addr_calc u_addr_calc (
        .y        (cmd_q.y),
        .row_base (row_base_calc)
    );

    // Next-state and next-output logic for the fill sequencer.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        col_d      = col_q;
        line_d     = line_q;
        row_base_d = row_base_q;
        wadr_d     = wadr_q;
        fbd_d      = fbd_q;
        reject_d   = reject_q;
        we_d       = 1'b0;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        skip       = 1'b0;

        accept = cmd_valid & ready_q;
        x_end  = {1'b0, cmd_q.x} + {1'b0, cmd_q.w};
        y_end  = {2'b0, cmd_q.y} + {2'b0, cmd_q.h};
        empty  = (cmd_q.w == 9'd0) || (cmd_q.h == 8'd0) ||
                 ({1'b0, cmd_q.x} >= W10) || ({2'b0, cmd_q.y} >= H10);

        case (state_q)
            IDLE: begin
                ready_d = ~accept;
                if (accept) begin
                    cmd_d.x     = cmd_x;
                    cmd_d.y     = cmd_y;
                    cmd_d.w     = cmd_w;
                    cmd_d.h     = cmd_h;
                    cmd_d.color = cmd_color;
                    busy_d      = 1'b1;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                x1_d       = (x_end > W10) ? W10 : x_end;
                y1_d       = (y_end > H10) ? H10 : y_end;
                col_d      = cmd_q.x;
                line_d     = cmd_q.y;
                row_base_d = row_base_calc;
                wadr_d     = row_base_calc + AW'(cmd_q.x);
                fbd_d      = cmd_q.color;
`ifdef FB_RECT_CLIP_EN
                reject_d   = 1'b0;
`else
                reject_d   = (cmd_q.w != 9'd0) && (cmd_q.h != 8'd0) &&
                             ((x_end > W10) || (y_end > H10));
`endif
                skip = empty || reject_d;
                if (skip) begin
                    state_d = DONE;
                end else begin
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                we_d   = 1'b1;
                busy_d = 1'b1;
                if ({1'b0, col_q} == x1_q - 10'd1) begin
                    if ({2'b0, line_q} == y1_q - 10'd1) begin
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        col_d      = cmd_q.x;
                        line_d     = line_q + 8'd1;
                        row_base_d = row_base_q + AW'(FB_W);
                        wadr_d     = row_base_q + AW'(FB_W) + AW'(cmd_q.x);
                    end
                end else begin
                    col_d  = col_q + 9'd1;
                    wadr_d = wadr_q + AW'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                err_d   = reject_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any fill without a done pulse.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            col_q      <= '0;
            line_q     <= '0;
            row_base_q <= '0;
            wadr_q     <= '0;
            fbd_q      <= '0;
            reject_q   <= 1'b0;
            we_q       <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            col_q      <= col_d;
            line_q     <= line_d;
            row_base_q <= row_base_d;
            wadr_q     <= wadr_d;
            fbd_q      <= fbd_d;
            reject_q   <= reject_d;
            we_q       <= we_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready = ready_q;
    assign fb_wadr   = wadr_q;
    assign fb_d      = fbd_q;
    assign fb_we     = we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
